// File: rtl/memory_value_reader.sv
// Reads one entry of a register array through a one-hot select and streams it
// out MSB chunk first; misses and out-of-range indices return a single error beat.
module memory_value_reader #(
  parameter int NUM_ENTRIES = 8,
  parameter int LENGTH      = 64,
  parameter int CHUNK       = 8,
  localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [IDX_W-1:0]       req_index,
  input  logic [NUM_ENTRIES-1:0] entry_valid,
  output logic [NUM_ENTRIES-1:0] select_op,
  input  logic [LENGTH-1:0]      rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CHUNK-1:0]       out_data,
  output logic                   out_last,
  output logic                   out_err,
  output logic                   busy
);

  localparam int BEATS = LENGTH / CHUNK;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEL    = 3'd1;
  localparam logic [2:0] S_CAP    = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  logic [2:0]       state_r;
  logic [LENGTH-1:0] shift_r;
  logic [CNT_W-1:0] cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic             hit_s;
  logic             last_s;

  // An index with no matching entry (out of range) yields zero, i.e. a miss.
  function automatic logic entry_hit(input logic [IDX_W-1:0] idx,
                                     input logic [NUM_ENTRIES-1:0] flags);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      hit = hit | ((idx == IDX_W'(i)) & flags[i]);
    end
    return hit;
  endfunction

  assign hit_s  = entry_hit(req_index, entry_valid);
  assign last_s = (cnt_r == CNT_W'(0));

  // State, captured data, beat counter and latched index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            idx_r   <= req_index;
            state_r <= hit_s ? S_SEL : S_ERR;
          end
        end
        S_SEL: begin
          state_r <= S_CAP;
        end
        S_CAP: begin
          shift_r <= rd_data;
          cnt_r   <= CNT_W'(BEATS - 1);
          state_r <= S_STREAM;
        end
        S_STREAM: begin
          if (out_ready) begin
            shift_r <= shift_r << CHUNK;
            if (last_s) begin
              state_r <= S_IDLE;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
        end
        S_ERR: begin
          if (out_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: every output is a function of the state and held registers only.
  always_comb begin
    req_ready = 1'b0;
    select_op = '0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_err   = 1'b0;
    busy      = 1'b1;
    case (state_r)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      S_SEL, S_CAP: begin
        select_op = {{(NUM_ENTRIES-1){1'b0}}, 1'b1} << idx_r;
      end
      S_STREAM: begin
        out_valid = 1'b1;
        out_data  = shift_r[LENGTH-1 -: CHUNK];
        out_last  = last_s;
      end
      S_ERR: begin
        out_valid = 1'b1;
        out_err   = 1'b1;
        out_last  = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

endmodule
